// File: rtl/keychain_pkg.sv
// -----------------------------------------------------------------------------
// keychain_pkg
// Shared definitions for the key-frame parsing path of the modular
// exponentiation pipeline: start-of-frame marker, coded error values and the
// parser state encoding.
//
// Build option: KEY_FRAME_CHECKSUM_EN adds the CHK state and the XOR
// accumulation helper used to verify the trailing checksum byte.
// -----------------------------------------------------------------------------
package keychain_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_CHECKSUM = 2'd2,
    ERR_OVERRUN  = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MSG  = 3'd1,
    ST_EXP  = 3'd2,
    ST_MOD  = 3'd3,
`ifdef KEY_FRAME_CHECKSUM_EN
    ST_CHK  = 3'd4,
`endif
    ST_HOLD = 3'd5
  } parser_state_e;

`ifdef KEY_FRAME_CHECKSUM_EN
  // Running checksum update: XOR of every payload byte seen so far.
  function automatic logic [7:0] xor_accumulate(input logic [7:0] acc,
                                                 input logic [7:0] data);
    return acc ^ data;
  endfunction
`endif

endpackage : keychain_pkg

// File: rtl/key_frame_parser_inter_byte_timer.sv
// -----------------------------------------------------------------------------
// inter_byte_timer
// Watchdog for gaps between bytes of a frame. Counts cycles while enabled
// and not restarted; raises 'expired' for one cycle when TIMEOUT_CYCLES
// consecutive cycles have passed without a restart. A restart in the same
// cycle suppresses expiry, so a late-but-present byte always wins.
//
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-high reset
//   enable   count only while high; low holds the counter at zero
//   restart  byte accepted this cycle; counter returns to zero
//   expired  one-cycle pulse in the cycle the gap reaches TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module inter_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Counter holds the number of idle cycles already completed; the cycle in
  // which it reads TIMEOUT_CYCLES-1 is the last allowed idle cycle.
  logic [CNT_W-1:0] gap_cnt_r;
  logic             expired_s;

  // Expiry decode: only while enabled and with no byte in the current cycle.
  always_comb begin
    expired_s = 1'b0;
    if (enable && !restart && (gap_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      expired_s = 1'b1;
    end else begin
      expired_s = 1'b0;
    end
  end

  // Gap counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gap_cnt_r <= {CNT_W{1'b0}};
    end else if (restart || !enable || expired_s) begin
      gap_cnt_r <= {CNT_W{1'b0}};
    end else begin
      gap_cnt_r <= gap_cnt_r + CNT_W'(1);
    end
  end

  assign expired = expired_s;

endmodule : inter_byte_timer

// File: rtl/key_frame_parser.sv
// -----------------------------------------------------------------------------
// key_frame_parser
// Byte-stream front end of the modular exponentiation path. Waits for the
// start-of-frame byte, shifts in big-endian message, exponent and modulus
// fields, then presents the completed frame with a one-cycle valid pulse.
// A frame completed while the downstream block is busy is held until it
// frees up; any byte arriving meanwhile drops the held frame (overrun).
// Stalled links abort via the inter-byte timer.
//
// Build option: KEY_FRAME_CHECKSUM_EN appends a checksum byte (XOR of all
// payload bytes) that must match for the frame to be presented.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   byte_valid_in   strobe: byte_in carries a received byte
//   byte_in         received byte
//   busy_in         downstream busy; a finished frame waits while high
//   valid_out       one-cycle pulse, field outputs carry a new frame
//   message_out     assembled message   (8*MSG_BYTES bits)
//   exponent_out    assembled exponent  (8*KEY_BYTES bits)
//   modulus_out     assembled modulus   (8*KEY_BYTES bits)
//   error_out       one-cycle pulse on frame abort
//   error_code_out  last error code, held until the next error or reset
// -----------------------------------------------------------------------------
module key_frame_parser
  import keychain_pkg::*;
#(
  parameter int MSG_BYTES      = 2,
  parameter int KEY_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   byte_valid_in,
  input  logic [7:0]             byte_in,
  input  logic                   busy_in,
  output logic                   valid_out,
  output logic [8*MSG_BYTES-1:0] message_out,
  output logic [8*KEY_BYTES-1:0] exponent_out,
  output logic [8*KEY_BYTES-1:0] modulus_out,
  output logic                   error_out,
  output logic [1:0]             error_code_out
);

  localparam int MSG_W     = 8 * MSG_BYTES;
  localparam int KEY_W     = 8 * KEY_BYTES;
  localparam int MAX_BYTES = (MSG_BYTES > KEY_BYTES) ? MSG_BYTES : KEY_BYTES;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  parser_state_e    state_r;
  parser_state_e    state_next_s;

  logic [CNT_W-1:0] byte_cnt_r;
  logic [CNT_W-1:0] byte_cnt_next_s;
  logic [MSG_W-1:0] msg_sh_r;
  logic [MSG_W-1:0] msg_next_s;
  logic [KEY_W-1:0] exp_sh_r;
  logic [KEY_W-1:0] exp_next_s;
  logic [KEY_W-1:0] mod_sh_r;
  logic [KEY_W-1:0] mod_next_s;

  logic             msg_last_s;
  logic             key_last_s;
  logic             timer_en_s;
  logic             timer_expired_s;
  logic             load_s;
  logic             err_s;
  err_code_e        err_code_s;

`ifdef KEY_FRAME_CHECKSUM_EN
  logic [7:0]       chk_r;
  logic [7:0]       chk_next_s;
  logic             chk_match_s;
  assign chk_match_s = (byte_in == chk_r);
`endif

  assign msg_last_s = (byte_cnt_r == CNT_W'(MSG_BYTES - 1));
  assign key_last_s = (byte_cnt_r == CNT_W'(KEY_BYTES - 1));

  // Timer runs only while a frame is being received, never in IDLE or HOLD.
  always_comb begin
    timer_en_s = 1'b0;
    case (state_r)
      ST_MSG:  timer_en_s = 1'b1;
      ST_EXP:  timer_en_s = 1'b1;
      ST_MOD:  timer_en_s = 1'b1;
`ifdef KEY_FRAME_CHECKSUM_EN
      ST_CHK:  timer_en_s = 1'b1;
`endif
      default: timer_en_s = 1'b0;
    endcase
  end

  inter_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_inter_byte_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .enable  (timer_en_s),
    .restart (byte_valid_in),
    .expired (timer_expired_s)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state selection. Expiry only fires in cycles without a byte, so
  // checking it first never hides an accepted byte.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (byte_valid_in && (byte_in == SOF_BYTE)) begin
          state_next_s = ST_MSG;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MSG: begin
        if (timer_expired_s) begin
          state_next_s = ST_IDLE;
        end else if (byte_valid_in && msg_last_s) begin
          state_next_s = ST_EXP;
        end else begin
          state_next_s = ST_MSG;
        end
      end
      ST_EXP: begin
        if (timer_expired_s) begin
          state_next_s = ST_IDLE;
        end else if (byte_valid_in && key_last_s) begin
          state_next_s = ST_MOD;
        end else begin
          state_next_s = ST_EXP;
        end
      end
      ST_MOD: begin
        if (timer_expired_s) begin
          state_next_s = ST_IDLE;
        end else if (byte_valid_in && key_last_s) begin
`ifdef KEY_FRAME_CHECKSUM_EN
          state_next_s = ST_CHK;
`else
          state_next_s = busy_in ? ST_HOLD : ST_IDLE;
`endif
        end else begin
          state_next_s = ST_MOD;
        end
      end
`ifdef KEY_FRAME_CHECKSUM_EN
      ST_CHK: begin
        if (timer_expired_s) begin
          state_next_s = ST_IDLE;
        end else if (byte_valid_in) begin
          state_next_s = (chk_match_s && busy_in) ? ST_HOLD : ST_IDLE;
        end else begin
          state_next_s = ST_CHK;
        end
      end
`endif
      ST_HOLD: begin
        if (byte_valid_in || !busy_in) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output/datapath decode: shadow shifts, byte counter, output load and
  // error strobes. The shadow "next" values include the byte accepted this
  // cycle, so a frame finishing on its last byte is loaded with latency 1.
  always_comb begin
    msg_next_s      = msg_sh_r;
    exp_next_s      = exp_sh_r;
    mod_next_s      = mod_sh_r;
    byte_cnt_next_s = byte_cnt_r;
    load_s          = 1'b0;
`ifdef KEY_FRAME_CHECKSUM_EN
    chk_next_s      = chk_r;
`endif
    if (timer_expired_s) begin
      err_s      = 1'b1;
      err_code_s = ERR_TIMEOUT;
    end else begin
      err_s      = 1'b0;
      err_code_s = ERR_NONE;
    end

    case (state_r)
      ST_IDLE: begin
        if (byte_valid_in && (byte_in == SOF_BYTE)) begin
          byte_cnt_next_s = {CNT_W{1'b0}};
`ifdef KEY_FRAME_CHECKSUM_EN
          chk_next_s      = 8'h00;
`endif
        end else begin
          byte_cnt_next_s = byte_cnt_r;
        end
      end
      ST_MSG: begin
        if (byte_valid_in) begin
          msg_next_s      = (msg_sh_r << 8) | MSG_W'(byte_in);
          byte_cnt_next_s = msg_last_s ? {CNT_W{1'b0}} : (byte_cnt_r + CNT_W'(1));
`ifdef KEY_FRAME_CHECKSUM_EN
          chk_next_s      = xor_accumulate(chk_r, byte_in);
`endif
        end else begin
          byte_cnt_next_s = byte_cnt_r;
        end
      end
      ST_EXP: begin
        if (byte_valid_in) begin
          exp_next_s      = (exp_sh_r << 8) | KEY_W'(byte_in);
          byte_cnt_next_s = key_last_s ? {CNT_W{1'b0}} : (byte_cnt_r + CNT_W'(1));
`ifdef KEY_FRAME_CHECKSUM_EN
          chk_next_s      = xor_accumulate(chk_r, byte_in);
`endif
        end else begin
          byte_cnt_next_s = byte_cnt_r;
        end
      end
      ST_MOD: begin
        if (byte_valid_in) begin
          mod_next_s      = (mod_sh_r << 8) | KEY_W'(byte_in);
          byte_cnt_next_s = key_last_s ? {CNT_W{1'b0}} : (byte_cnt_r + CNT_W'(1));
`ifdef KEY_FRAME_CHECKSUM_EN
          chk_next_s      = xor_accumulate(chk_r, byte_in);
`else
          load_s          = key_last_s && !busy_in;
`endif
        end else begin
          byte_cnt_next_s = byte_cnt_r;
        end
      end
`ifdef KEY_FRAME_CHECKSUM_EN
      ST_CHK: begin
        if (byte_valid_in && chk_match_s) begin
          load_s = !busy_in;
        end else if (byte_valid_in) begin
          err_s      = 1'b1;
          err_code_s = ERR_CHECKSUM;
        end else begin
          load_s = 1'b0;
        end
      end
`endif
      ST_HOLD: begin
        // Any byte while holding means the sender ran ahead of the consumer.
        if (byte_valid_in) begin
          err_s      = 1'b1;
          err_code_s = ERR_OVERRUN;
        end else begin
          load_s = !busy_in;
        end
      end
      default: begin
        byte_cnt_next_s = {CNT_W{1'b0}};
      end
    endcase

    // An aborted frame leaves the counter clean for the next SOF.
    if (err_s) begin
      byte_cnt_next_s = {CNT_W{1'b0}};
    end else begin
      byte_cnt_next_s = byte_cnt_next_s;
    end
  end

  // Shadow fields, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      byte_cnt_r     <= {CNT_W{1'b0}};
      msg_sh_r       <= {MSG_W{1'b0}};
      exp_sh_r       <= {KEY_W{1'b0}};
      mod_sh_r       <= {KEY_W{1'b0}};
      valid_out      <= 1'b0;
      error_out      <= 1'b0;
      error_code_out <= 2'd0;
      message_out    <= {MSG_W{1'b0}};
      exponent_out   <= {KEY_W{1'b0}};
      modulus_out    <= {KEY_W{1'b0}};
`ifdef KEY_FRAME_CHECKSUM_EN
      chk_r          <= 8'h00;
`endif
    end else begin
      byte_cnt_r <= byte_cnt_next_s;
      msg_sh_r   <= msg_next_s;
      exp_sh_r   <= exp_next_s;
      mod_sh_r   <= mod_next_s;
      valid_out  <= load_s;
      error_out  <= err_s;
`ifdef KEY_FRAME_CHECKSUM_EN
      chk_r      <= chk_next_s;
`endif
      if (load_s) begin
        message_out  <= msg_next_s;
        exponent_out <= exp_next_s;
        modulus_out  <= mod_next_s;
      end
      if (err_s) begin
        error_code_out <= err_code_s;
      end
    end
  end

endmodule : key_frame_parser

// File: doc/key_frame_parser.md
Name: key_frame_parser

Overview:
Upstream stage of the modular-exponentiation path. Consumes the byte stream from the UART byte receiver and detects start-of-frame. Assembles big-endian message, exponent and modulus fields, then presents them to the exponent_modulus block with a one-cycle valid pulse. Also guards against stalled links and back-pressure overrun, reporting these as coded errors.

Parameters:
MSG_BYTES, 2, message field width in bytes (>=1)
KEY_BYTES, 4, exponent and modulus field width in bytes (>=1)
TIMEOUT_CYCLES, 50_000, max clk_in cycles between bytes inside a frame before abort (>=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
byte_valid_in  input  1  one-cycle strobe: byte_in holds a received byte
byte_in  input  8  received byte
busy_in  input  1  downstream expmod busy; completed frame is held while high
valid_out  output  1  one-cycle pulse: field outputs hold a new frame
message_out  output  8*MSG_BYTES  assembled message
exponent_out  output  8*KEY_BYTES  assembled exponent
modulus_out  output  8*KEY_BYTES  assembled modulus
error_out  output  1  one-cycle pulse on frame abort
error_code_out  output  2  0 none, 1 timeout, 2 checksum, 3 overrun; held until next error or reset

Behaviour:
- Clock and reset:
  - One clock, clk_in. Reset rst_in is synchronous and active-high.
  - Reset clears every output to 0, the state to IDLE and all counters.
  - Reset mid-frame discards the partial frame without raising error_out.
- Frame format: SOF byte 0xA5, then MSG_BYTES message, then KEY_BYTES exponent, then KEY_BYTES modulus.
  - Each field is sent MSB first.
  - A checksum byte follows when the optional feature below is enabled.
- Internal fields are shift registers; a byte shifts into the LSB of the current field.
- Outputs are updated only on frame completion, so fields stay stable between valid_out pulses.
- FSM states: IDLE, MSG, EXP, MOD, [CHK], HOLD.
  - IDLE:
    - byte 0xA5 -> MSG, byte counter=0.
    - Any other byte is ignored silently, with no error.
  - MSG / EXP / MOD: each accepted byte increments the counter.
    - On the field's last byte, go to the next field with counter=0.
    - After MOD: go to CHK if enabled, else to completion.
  - Completion, busy_in low: copy shadow fields to outputs and pulse valid_out the cycle after the last byte is accepted (latency 1). Go to IDLE.
  - Completion, busy_in high: go to HOLD.
  - HOLD: remain until busy_in low, then copy, pulse valid_out next cycle and go to IDLE.
  - A byte_valid_in during HOLD drops the held frame: error_code=3, pulse error_out, go to IDLE. That byte is not parsed as SOF.
- Timeout:
  - The inter-byte counter runs in MSG/EXP/MOD/CHK and resets on each accepted byte.
  - It does not run in IDLE or HOLD.
  - At TIMEOUT_CYCLES cycles without a byte: error_code=1, pulse error_out, go to IDLE.
  - A byte arriving in the same cycle the timeout would fire wins; no timeout occurs.
- A 0xA5 inside the payload is data; there is no resynchronisation mid-frame.
- valid_out and error_out are never asserted in the same cycle.

Optional Feature:
- Macro: KEY_FRAME_CHECKSUM_EN.
- When defined:
  - CHK state expects one byte equal to the XOR of all payload bytes, excluding SOF.
  - Match -> completion as above.
  - Mismatch -> error_code=2, pulse error_out, outputs unchanged, go to IDLE.
  - The running XOR resets on SOF.
- When undefined: no CHK state and no XOR logic; error code 2 never occurs.

Decomposition:
- keychain_pkg holds:
  - SOF_BYTE constant (8'hA5)
  - error code enum (ERR_NONE, ERR_TIMEOUT, ERR_CHECKSUM, ERR_OVERRUN)
  - parser state enum
- Sub-module inter_byte_timer:
  - Parameter TIMEOUT_CYCLES.
  - Inputs clk_in, rst_in, enable, restart. Output expired pulse.
  - Counter width $clog2(TIMEOUT_CYCLES+1).
- Field assembly stays inline in key_frame_parser.

Test Plan:
All scenarios use MSG_BYTES=2 and KEY_BYTES=4.
- Clean frame: A5 12 34 00 01 00 01 00 00 0F 0B (+22 if checksum enabled), busy_in=0 -> one valid_out pulse one cycle after the last byte; message_out=0x1234, exponent_out=0x00010001, modulus_out=0x00000F0B; error_out never asserted.
- Leading garbage 00 FF 5A, then the clean frame -> identical result, no error.
- Stall: send A5 12 34, then no bytes for TIMEOUT_CYCLES (set 100 in bench) -> error_out pulse, error_code_out=1, outputs still 0. A following clean frame parses correctly.
- Back-pressure: busy_in=1 while the clean frame completes, release 20 cycles later -> valid_out pulse the cycle after release.
- Overrun: repeat the back-pressure case but send byte 0x00 during HOLD -> error_code_out=3, no valid_out.
- Checksum (KEY_FRAME_CHECKSUM_EN): clean frame with final byte 0x23 -> error_code_out=2, no valid_out, outputs unchanged.
- Reset: assert rst_in after A5 12 -> all outputs 0, no error_out. Then send the clean frame -> parses correctly.
